ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_fifo.sv | 90 +++++++++
 rtl/ifu.sv | 165 ++++++++++++++++
 tb/tb_ifu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared IFU definitions: widths, reset PC default and FSM state encoding.
package ifu_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          INSTR_WIDTH  = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ifu_state_e;

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry instruction FIFO holding fetched word, its PC and access-fault flag.
// A flush empties it in one cycle and takes priority over read and write.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [INSTR_WIDTH-1:0] wr_data_i,
    input  logic [XLEN-1:0]        wr_pc_i,
    input  logic                   wr_err_i,
    input  logic                   rd_en_i,
    output logic [INSTR_WIDTH-1:0] rd_data_o,
    output logic [XLEN-1:0]        rd_pc_o,
    output logic                   rd_err_o,
    output logic                   empty_o,
    output logic [1:0]             count_o
);

    logic [INSTR_WIDTH-1:0] data_q [0:1];
    logic [INSTR_WIDTH-1:0] data_d [0:1];
    logic [XLEN-1:0]        pc_q   [0:1];
    logic [XLEN-1:0]        pc_d   [0:1];
    logic [1:0]             err_q;
    logic [1:0]             err_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        data_d   = data_q;
        pc_d     = pc_q;
        err_d    = err_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (wr_en_i) begin
                data_d[wr_ptr_q] = wr_data_i;
                pc_d[wr_ptr_q]   = wr_pc_i;
                err_d[wr_ptr_q]  = wr_err_i;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, wr_en_i} - {1'b0, rd_en_i};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q[0] <= {INSTR_WIDTH{1'b0}};
            data_q[1] <= {INSTR_WIDTH{1'b0}};
            pc_q[0]   <= {XLEN{1'b0}};
            pc_q[1]   <= {XLEN{1'b0}};
            err_q     <= 2'b00;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            data_q   <= data_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_data_o = data_q[rd_ptr_q];
    assign rd_pc_o   = pc_q[rd_ptr_q];
    assign rd_err_o  = err_q[rd_ptr_q];
    assign empty_o   = (cnt_q == 2'd0);
    assign count_o   = cnt_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: issues sequential fetches, buffers up to two
// responses, delivers them to decode and handles redirects and faults.
// Optional feature macro: IFU_MISALIGN_CHK_EN (misaligned redirect check,
// adds the ifu_misalign_o port).
module ifu
    import ifu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF[XLEN-1:0]
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   ifu_req_valid_o,
    input  logic                   ifu_req_ready_i,
    output logic [XLEN-1:0]        ifu_req_addr_o,
    input  logic                   ifu_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] ifu_rsp_data_i,
    input  logic                   ifu_rsp_err_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   ifu_instr_valid_o,
    input  logic                   ifu_instr_ready_i,
    output logic [INSTR_WIDTH-1:0] ifu_instr_o,
    output logic [XLEN-1:0]        ifu_pc_o,
    output logic                   ifu_fault_o
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                   ifu_misalign_o
`endif
);

    ifu_state_e       state_q, state_d;
    logic [XLEN-1:0]  fpc_q, fpc_d;     // next fetch address
    logic [XLEN-1:0]  dpc_q, dpc_d;     // PC of the entry at the delivery head
    logic [1:0]       out_q, out_d;     // requests accepted, response pending
    logic [1:0]       disc_q, disc_d;   // pending responses that are stale
    logic             mis_q, mis_d;     // misaligned-target pseudo entry

    logic                   req_fire_s, rsp_cnt_s, deq_s, fault_deq_s;
    logic                   fifo_wr_s, fifo_rd_s, fifo_flush_s;
    logic [INSTR_WIDTH-1:0] fifo_data_s;
    logic [XLEN-1:0]        fifo_pc_s, tgt_s;
    logic                   fifo_err_s, fifo_empty_s, mis_tgt_s;
    logic [1:0]             fifo_cnt_s;

    ifu_fifo #(.XLEN(XLEN)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (fifo_flush_s),
        .wr_en_i   (fifo_wr_s),
        .wr_data_i (ifu_rsp_data_i),
        .wr_pc_i   (dpc_q + {{(XLEN-4){1'b0}}, fifo_cnt_s, 2'b00}),
        .wr_err_i  (ifu_rsp_err_i),
        .rd_en_i   (fifo_rd_s),
        .rd_data_o (fifo_data_s),
        .rd_pc_o   (fifo_pc_s),
        .rd_err_o  (fifo_err_s),
        .empty_o   (fifo_empty_s),
        .count_o   (fifo_cnt_s)
    );

    // Redirect target; misaligned targets are either flagged or rounded down.
    always_comb begin
`ifdef IFU_MISALIGN_CHK_EN
        tgt_s     = redirect_pc_i;
        mis_tgt_s = (redirect_pc_i[1:0] != 2'b00);
`else
        tgt_s     = {redirect_pc_i[XLEN-1:2], 2'b00};
        mis_tgt_s = 1'b0;
`endif
    end

    // Handshakes; request gating uses only registered occupancy.
    always_comb begin
        ifu_req_valid_o   = (state_q == ST_RUN) && !redirect_i && !rst_i &&
                            (({1'b0, out_q} + {1'b0, fifo_cnt_s}) < 3'd2);
        ifu_req_addr_o    = fpc_q;
        req_fire_s        = ifu_req_valid_o && ifu_req_ready_i;
        // A response with nothing outstanding belongs to a pre-reset request.
        rsp_cnt_s         = ifu_rsp_valid_i && (out_q != 2'd0);
        ifu_instr_valid_o = mis_q || !fifo_empty_s;
        deq_s             = ifu_instr_valid_o && ifu_instr_ready_i;
        fifo_rd_s         = deq_s && !mis_q;
        fault_deq_s       = fifo_rd_s && fifo_err_s;
        ifu_instr_o       = mis_q ? {INSTR_WIDTH{1'b0}} : fifo_data_s;
        ifu_pc_o          = mis_q ? dpc_q : fifo_pc_s;
        ifu_fault_o       = !mis_q && !fifo_empty_s && fifo_err_s;
    end

`ifdef IFU_MISALIGN_CHK_EN
    assign ifu_misalign_o = mis_q;
`endif

    // Next-state: PCs, counters, FSM and FIFO write/flush control.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        dpc_d        = dpc_q;
        mis_d        = mis_q;
        disc_d       = disc_q;
        fifo_wr_s    = 1'b0;
        fifo_flush_s = 1'b0;
        out_d        = out_q + {1'b0, req_fire_s} - {1'b0, rsp_cnt_s};
        if (redirect_i) begin
            // Everything still in flight after this edge is wrong-path.
            fpc_d        = tgt_s;
            dpc_d        = tgt_s;
            fifo_flush_s = 1'b1;
            disc_d       = out_d;
            if (mis_tgt_s) begin
                state_d = ST_HALT;
                mis_d   = 1'b1;
            end else begin
                state_d = ST_RUN;
                mis_d   = 1'b0;
            end
        end else begin
            if (req_fire_s) begin
                fpc_d = fpc_q + {{(XLEN-3){1'b0}}, 3'd4};
            end else begin
                fpc_d = fpc_q;
            end
            if (rsp_cnt_s && (disc_q != 2'd0)) begin
                disc_d = disc_q - 2'd1;
            end else begin
                disc_d = disc_q;
            end
            fifo_wr_s = rsp_cnt_s && (disc_q == 2'd0) && (state_q == ST_RUN) && !fault_deq_s;
            if (deq_s) begin
                dpc_d = dpc_q + {{(XLEN-3){1'b0}}, 3'd4};
                mis_d = 1'b0;
            end else begin
                dpc_d = dpc_q;
                mis_d = mis_q;
            end
            // Entries behind a faulting one are never delivered.
            if (fault_deq_s) begin
                state_d      = ST_HALT;
                fifo_flush_s = 1'b1;
            end else begin
                state_d = state_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            fpc_q   <= RESET_PC;
            dpc_q   <= RESET_PC;
            out_q   <= 2'd0;
            disc_q  <= 2'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            dpc_q   <= dpc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu with a 1-cycle-latency memory model and a
// scoreboard of expected deliveries checked by an independent monitor.
module tb_ifu;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, rsp_valid, rsp_err, redirect;
    logic        instr_valid, instr_ready, fault, mis;
    logic [63:0] req_addr, redirect_pc, pc;
    logic [31:0] rsp_data, instr;

    always #5 clk = ~clk;

    ifu #(.XLEN(64), .RESET_PC(64'h0000_0000_8000_0000)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ifu_req_valid_o   (req_valid),
        .ifu_req_ready_i   (req_ready),
        .ifu_req_addr_o    (req_addr),
        .ifu_rsp_valid_i   (rsp_valid),
        .ifu_rsp_data_i    (rsp_data),
        .ifu_rsp_err_i     (rsp_err),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .ifu_instr_valid_o (instr_valid),
        .ifu_instr_ready_i (instr_ready),
        .ifu_instr_o       (instr),
        .ifu_pc_o          (pc),
        .ifu_fault_o       (fault)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .ifu_misalign_o    (mis)
`endif
    );

`ifndef IFU_MISALIGN_CHK_EN
    assign mis = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] mem_q[$];
    logic [63:0] req_log[$];
    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    logic        mem_en = 1'b1;
    logic        err_en = 1'b0;
    logic [63:0] err_addr = 64'h0;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic push_exp(input logic [63:0] p, input logic [31:0] w, input logic f, input logic m);
        exp_t e;
        e.pc = p; e.instr = w; e.fault = f; e.mis = m;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input logic [63:0] p);
        push_exp(p, word_of(p), 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic logic [63:0] log_at(input int i);
        return (req_log.size() > i) ? req_log[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic wait_deliv(input int target, input string nm);
        int n = 0;
        while (delivered < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(nm, 64'(delivered >= target), 64'd1);
    endtask

    // Memory model: one-cycle response latency, responses held while mem_en is low.
    always begin
        logic [63:0] a;
        @(negedge clk);
        #1;
        if (mem_en && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = word_of(a);
            rsp_err   = err_en && (a == err_addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
            rsp_err   = 1'b0;
        end
        #1;
        if (!rst && req_valid === 1'b1 && req_ready) begin
            mem_q.push_back(req_addr);
            req_log.push_back(req_addr);
        end
    end

    // Monitor: pops the scoreboard on every decode handshake.
    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (!rst && instr_valid === 1'b1 && instr_ready) begin
            delivered++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_delivery pc=%h instr=%h", pc, instr);
            end else begin
                e = exp_q.pop_front();
                if (pc !== e.pc || instr !== e.instr || fault !== e.fault || mis !== e.mis) begin
                    bad++;
                    $display("FAIL delivery got pc=%h instr=%h fault=%b mis=%b want pc=%h instr=%h fault=%b mis=%b",
                             pc, instr, fault, mis, e.pc, e.instr, e.fault, e.mis);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_ready = 1'b1; redirect = 1'b0; redirect_pc = 64'h0;
        instr_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_misalign", 64'(mis), 64'd0);

        // Reset release with decode stalled: two fetches then buffer full.
        @(negedge clk);
        rst = 1'b0;
        mem_q.delete();
        req_log.delete();
        #3;
        chk("first_req_valid", 64'(req_valid), 64'd1);
        chk("first_req_addr", req_addr, 64'h8000_0000);
        repeat (8) @(negedge clk);
        #3;
        chk("stall_req_valid", 64'(req_valid), 64'd0);
        chk("stall_instr_valid", 64'(instr_valid), 64'd1);
        chk("stall_head_pc", pc, 64'h8000_0000);
        chk("stall_req_count", 64'(req_log.size()), 64'd2);
        chk("req0_addr", log_at(0), 64'h8000_0000);
        chk("req1_addr", log_at(1), 64'h8000_0004);
        push_seq(64'h8000_0000);
        push_seq(64'h8000_0004);

        // Drain with memory silent: two requests left outstanding.
        @(negedge clk);
        mem_en = 1'b0;
        instr_ready = 1'b1;
        wait_deliv(2, "deliv_initial");
        repeat (4) @(negedge clk);
        #3;
        chk("outst_req_valid", 64'(req_valid), 64'd0);
        chk("outst_req_count", 64'(req_log.size()), 64'd4);
        chk("req3_addr", log_at(3), 64'h8000_000C);

        // Redirect with two stale responses pending.
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h8000_1000;
        #3;
        chk("redir_req_forced_low", 64'(req_valid), 64'd0);
        push_seq(64'h8000_1000);
        push_seq(64'h8000_1004);
        push_seq(64'h8000_1008);
        push_seq(64'h8000_100C);
        @(negedge clk);
        redirect = 1'b0;
        mem_en = 1'b1;
        wait_deliv(6, "deliv_after_redirect");
        @(negedge clk);
        instr_ready = 1'b0;
        chk("req4_addr", log_at(4), 64'h8000_1000);
        repeat (6) @(negedge clk);
        #3;
        chk("full_head_pc", pc, 64'h8000_1010);
        chk("full_req_valid", 64'(req_valid), 64'd0);
        push_seq(64'h8000_1010);
        push_seq(64'h8000_1014);

        // Redirect coinciding with a response and a dequeue.
        @(negedge clk);
        mem_en = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        #3;
        chk("pre_race_req_addr", req_addr, 64'h8000_1018);
        @(negedge clk);
        mem_en = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 64'h8000_0000;
        err_en = 1'b1;
        err_addr = 64'h8000_0008;
        #3;
        chk("race_head_pc", pc, 64'h8000_1014);
        push_seq(64'h8000_0000);
        push_seq(64'h8000_0004);
        push_exp(64'h8000_0008, word_of(64'h8000_0008), 1'b1, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("race_fifo_empty", 64'(instr_valid), 64'd0);
        chk("race_next_req", req_addr, 64'h8000_0000);

        // Access fault: delivered flagged, then fetch stops.
        wait_deliv(11, "deliv_fault");
        repeat (6) @(negedge clk);
        #3;
        chk("halt_req_valid", 64'(req_valid), 64'd0);
        chk("halt_instr_valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        err_en = 1'b0;
        redirect = 1'b1;
        redirect_pc = 64'h8000_2000;
        @(negedge clk);
        redirect = 1'b0;
        #3;
        chk("resume_req_valid", 64'(req_valid), 64'd1);
        chk("resume_req_addr", req_addr, 64'h8000_2000);
        push_seq(64'h8000_2000);
        wait_deliv(12, "deliv_resume");
        @(negedge clk);
        instr_ready = 1'b0;
        repeat (4) @(negedge clk);

        // Misaligned redirect target.
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 64'h8000_0002;
`ifdef IFU_MISALIGN_CHK_EN
        push_exp(64'h8000_0002, 32'h0, 1'b0, 1'b1);
`else
        push_seq(64'h8000_0000);
`endif
        @(negedge clk);
        redirect = 1'b0;
        instr_ready = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
        #3;
        chk("misalign_no_req", 64'(req_valid), 64'd0);
        wait_deliv(13, "deliv_misalign");
        repeat (5) @(negedge clk);
        #3;
        chk("misalign_halt_req", 64'(req_valid), 64'd0);
        chk("misalign_single_entry", 64'(instr_valid), 64'd0);
`else
        wait_deliv(13, "deliv_aligned_down");
        @(negedge clk);
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
`endif
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
